gmsk_burst_rx: RTL and testbench
================================

GMSK_BURST_RX -- requirements
Module: gmsk_burst_rx

Interface
REQ-001 SHALL have parameter SAMPLES_PER_SYMBOL, default 8, ADC samples per symbol; power of two, 4..16.
REQ-002 SHALL have parameter SYNC_WORD, default 16'hB5E3, expected sync pattern; MSB is received first.
REQ-003 SHALL have parameter SYNC_MAX_ERR, default 1, max Hamming distance accepted as sync.
REQ-004 SHALL have parameter PAYLOAD_BITS, default 116, bits delivered after sync.
REQ-005 SHALL have port clock  in  1  single clock, all logic on posedge.
REQ-006 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port sample_strobe  in  1  qualifies adc_inphase/adc_quadrature for one clock.
REQ-008 SHALL have port adc_inphase  in  6  offset-binary I, midscale 32.
REQ-009 SHALL have port adc_quadrature  in  6  offset-binary Q, midscale 32.
REQ-010 SHALL have port rx_enable  in  1  level; high permits burst search.
REQ-011 SHALL have port is_armed  out  1  high while in SEARCH.
REQ-012 SHALL have port sync_found  out  1  one-clock pulse on sync acceptance.
REQ-013 SHALL have port bit_out  out  1  demodulated payload bit, valid with bit_strobe.
REQ-014 SHALL have port bit_strobe  out  1  one-clock pulse per payload bit.
REQ-015 SHALL have port burst_done  out  1  one-clock pulse after the last payload bit.

Function
REQ-016 SHALL convert each strobed sample to 6-bit signed by subtracting 32 (I' = I-32, Q' = Q-32).
REQ-017 SHALL compute d = Iprev'*Qcur' - Qprev'*Icur' at 13-bit signed width with no truncation; prev is the previous strobed sample.
REQ-018 SHALL register the decision s = (d > 0) one clock after sample_strobe; d == 0 gives 0.
REQ-019 SHALL keep a phase counter 0..SAMPLES_PER_SYMBOL-1, advanced per strobed sample, wrapping to 0.
REQ-020 SHALL produce a symbol decision at the sample where phase == SAMPLES_PER_SYMBOL/2.
REQ-021 SHALL, in SEARCH, reset phase to 0 on the sample whose s differs from the previous s (timing resync).
REQ-022 SHALL implement FSM states IDLE, SEARCH, PAYLOAD, DONE.
REQ-023 IDLE->SEARCH when rx_enable is high; entry clears the sync shift register, bit-fill count and phase.
REQ-024 SEARCH: each decision shifts into a 16-bit register at the LSB; once at least 16 decisions have been taken and the Hamming distance to SYNC_WORD is <= SYNC_MAX_ERR, the FSM goes to PAYLOAD and pulses sync_found in the same clock as the transition.
REQ-025 PAYLOAD: each decision drives bit_out with bit_strobe, 2 clocks after the center sample's sample_strobe; a payload counter counts to PAYLOAD_BITS.
REQ-026 After the PAYLOAD_BITS-th bit_strobe the FSM SHALL enter DONE; DONE pulses burst_done for one clock, then goes to IDLE.
REQ-027 rx_enable low in any state SHALL force IDLE on the next clock; no burst_done or further bit_strobe.
REQ-028 sync_found, bit_strobe and burst_done SHALL never assert in the same clock.
REQ-029 A sample_strobe held high on consecutive clocks SHALL be processed as one sample per clock.

Reset
REQ-030 reset_n low SHALL asynchronously force: state IDLE; phase, counters, shift register and previous-sample registers 0; all outputs 0.

Configuration
REQ-031 With GMSK_RX_TIMING_TRACK_EN defined, the REQ-021 resync SHALL also be active in PAYLOAD.
REQ-032 Without GMSK_RX_TIMING_TRACK_EN, phase SHALL free-run (no resync) in PAYLOAD.

Structure
REQ-033 Package gmsk_rx_pkg SHALL hold the state enum, the widths (sample 6, product 12, discriminator 13) and the midscale constant 32.
REQ-034 Sub-module gmsk_discriminator SHALL hold the offset removal, previous-sample register, cross product and sign register (REQ-016..018).

Verification
REQ-035 Reset asserted mid-PAYLOAD -> all outputs 0 immediately; after release the block stays IDLE until rx_enable is high.
REQ-036 Noise-free GMSK burst (SPS 8, 8 random bits + SYNC_WORD 16'hB5E3 + 116 known bits) -> one sync_found, 116 bit_strobe matching the bits exactly, then one burst_done.
REQ-037 Sync word with 1 bit flipped -> accepted; with 2 bits flipped -> no sync_found and is_armed stays high.
REQ-038 rx_enable dropped after payload bit 50 -> IDLE next clock, no further bit_strobe, no burst_done.
REQ-039 Constant sample I=63, Q=32 for every strobe -> d == 0 and all decisions 0; never syncs.
REQ-040 Payload with the TX clock 0.5% fast -> all 116 bits correct with GMSK_RX_TIMING_TRACK_EN defined; mismatch tolerated without it.

Source files
------------

// File: rtl/gmsk_rx_pkg.sv
// gmsk_rx_pkg: shared FSM state type, datapath widths and ADC midscale for the GMSK burst receiver
package gmsk_rx_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_PAYLOAD, ST_DONE} state_e;
   localparam int SAMPLE_W = 6;
   localparam int PROD_W = 12;
   localparam int DISC_W = 13;
   localparam logic [SAMPLE_W-1:0] MIDSCALE = 6'd32;
endpackage

// File: rtl/gmsk_discriminator.sv
// gmsk_discriminator: offset removal, previous-sample store, cross-product and registered sign decision
//   clock, reset_n : clock, async active-low reset
//   strobe_i       : qualifies inph_i/quad_i (offset-binary) for one clock
//   valid_o        : one-clock pulse, the clock after strobe_i
//   bit_o          : registered decision (Iprev*Qcur - Qprev*Icur) > 0
module gmsk_discriminator
   import gmsk_rx_pkg::*;
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                strobe_i,
   input  logic [SAMPLE_W-1:0] inph_i,
   input  logic [SAMPLE_W-1:0] quad_i,
   output logic                valid_o,
   output logic                bit_o
);
   logic signed [SAMPLE_W-1:0] i_cur, q_cur, i_prev_q, q_prev_q;
   logic signed [PROD_W-1:0]   p_a, p_b;
   logic signed [DISC_W-1:0]   d;
   logic                       valid_q, bit_q;
   assign i_cur = $signed(inph_i - MIDSCALE);
   assign q_cur = $signed(quad_i - MIDSCALE);
   assign p_a = PROD_W'(i_prev_q) * PROD_W'(q_cur);
   assign p_b = PROD_W'(q_prev_q) * PROD_W'(i_cur);
   assign d = DISC_W'(p_a) - DISC_W'(p_b);
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         i_prev_q <= '0;
         q_prev_q <= '0;
         valid_q  <= 1'b0;
         bit_q    <= 1'b0;
      end else begin
         valid_q <= strobe_i;
         if (strobe_i) begin
            i_prev_q <= i_cur;
            q_prev_q <= q_cur;
            bit_q    <= !d[DISC_W-1] && (d != '0);
         end
      end
   end
   assign valid_o = valid_q;
   assign bit_o = bit_q;
endmodule

// File: rtl/gmsk_burst_rx.sv
// gmsk_burst_rx: GMSK burst receiver -- differential discriminator, symbol timing, sync search, payload delivery
//   clock, reset_n                      : clock, async active-low reset
//   sample_strobe, adc_inphase/quadrature : strobed offset-binary I/Q samples
//   rx_enable                           : level, permits burst search; low forces IDLE
//   is_armed                            : high while searching for sync
//   sync_found, bit_strobe/bit_out, burst_done : registered one-clock event pulses
// Build option: GMSK_RX_TIMING_TRACK_EN keeps transition resync active during the payload.
module gmsk_burst_rx
   import gmsk_rx_pkg::*;
#(
   parameter int          SAMPLES_PER_SYMBOL = 8,
   parameter logic [15:0] SYNC_WORD          = 16'hB5E3,
   parameter int          SYNC_MAX_ERR       = 1,
   parameter int          PAYLOAD_BITS       = 116
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                sample_strobe,
   input  logic [SAMPLE_W-1:0] adc_inphase,
   input  logic [SAMPLE_W-1:0] adc_quadrature,
   input  logic                rx_enable,
   output logic                is_armed,
   output logic                sync_found,
   output logic                bit_out,
   output logic                bit_strobe,
   output logic                burst_done
);
   localparam int PW = $clog2(SAMPLES_PER_SYMBOL);
   localparam int CW = $clog2(PAYLOAD_BITS + 1);
   localparam logic [PW-1:0] CENTER = PW'(SAMPLES_PER_SYMBOL / 2);
   localparam logic [CW-1:0] LAST_BIT = CW'(PAYLOAD_BITS - 1);
   localparam logic [4:0] FULL = 5'd16;
   state_e          state_q;
   logic [PW-1:0]   phase_q, phase_cur;
   logic [15:0]     shift_q, shift_d;
   logic [4:0]      fill_q, fill_d;
   logic [CW-1:0]   pay_cnt_q;
   logic            s_prev_q, dv, db, resync_en, resync, center, hit;
   logic            is_armed_q, sync_found_q, bit_out_q, bit_strobe_q, burst_done_q;
   gmsk_discriminator u_disc (
      .clock    (clock),
      .reset_n  (reset_n),
      .strobe_i (sample_strobe),
      .inph_i   (adc_inphase),
      .quad_i   (adc_quadrature),
      .valid_o  (dv),
      .bit_o    (db)
   );
`ifdef GMSK_RX_TIMING_TRACK_EN
   assign resync_en = (state_q == ST_SEARCH) || (state_q == ST_PAYLOAD);
`else
   assign resync_en = (state_q == ST_SEARCH);
`endif
   // A decision transition marks a symbol boundary: that sample becomes phase 0,
   // so the centre sample lands half a symbol later.
   assign resync = dv && resync_en && (db != s_prev_q);
   assign phase_cur = resync ? '0 : phase_q;
   assign center = dv && (phase_cur == CENTER);
   assign shift_d = {shift_q[14:0], db};
   assign fill_d = (fill_q == FULL) ? fill_q : fill_q + 5'd1;
   assign hit = (fill_d == FULL) && ($countones(shift_d ^ SYNC_WORD) <= SYNC_MAX_ERR);
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         shift_q      <= '0;
         fill_q       <= '0;
         pay_cnt_q    <= '0;
         s_prev_q     <= 1'b0;
         is_armed_q   <= 1'b0;
         sync_found_q <= 1'b0;
         bit_out_q    <= 1'b0;
         bit_strobe_q <= 1'b0;
         burst_done_q <= 1'b0;
      end else begin
         sync_found_q <= 1'b0;
         bit_strobe_q <= 1'b0;
         burst_done_q <= 1'b0;
         if (dv) begin
            s_prev_q <= db;
            phase_q  <= phase_cur + PW'(1);
         end
         if (!rx_enable) begin
            state_q    <= ST_IDLE;
            is_armed_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q    <= ST_SEARCH;
                  is_armed_q <= 1'b1;
                  shift_q    <= '0;
                  fill_q     <= '0;
                  phase_q    <= '0;
               end
               ST_SEARCH: if (center) begin
                  shift_q <= shift_d;
                  fill_q  <= fill_d;
                  if (hit) begin
                     state_q      <= ST_PAYLOAD;
                     is_armed_q   <= 1'b0;
                     sync_found_q <= 1'b1;
                     pay_cnt_q    <= '0;
                  end
               end
               ST_PAYLOAD: if (center) begin
                  bit_out_q    <= db;
                  bit_strobe_q <= 1'b1;
                  pay_cnt_q    <= pay_cnt_q + CW'(1);
                  if (pay_cnt_q == LAST_BIT) state_q <= ST_DONE;
               end
               default: begin
                  burst_done_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            endcase
         end
      end
   end
   assign is_armed = is_armed_q;
   assign sync_found = sync_found_q;
   assign bit_out = bit_out_q;
   assign bit_strobe = bit_strobe_q;
   assign burst_done = burst_done_q;
endmodule

// File: tb/tb_gmsk_burst_rx.sv
// tb_gmsk_burst_rx: randomized MSK-style burst stimulus checked against a bit-level reference of the receiver
module tb_gmsk_burst_rx;
   logic       clock = 1'b0, reset_n = 1'b0, sample_strobe = 1'b0, rx_enable = 1'b0;
   logic [5:0] adc_inphase = 6'd32, adc_quadrature = 6'd32;
   logic       is_armed, sync_found, bit_out, bit_strobe, burst_done;
   int         total = 0, bad = 0;
   int         cyc = 0, nsync = 0, ndone = 0, ovl = 0, last_bs = 0, done_cyc = 0, bits_at_done = 0;
   bit         rxq[$];
   real        th = 0.3;
   localparam real AMP = 28.0;
   localparam real HALFPI = 1.5707963267948966;
   localparam real NOM = 0.125;

   gmsk_burst_rx dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .sample_strobe  (sample_strobe),
      .adc_inphase    (adc_inphase),
      .adc_quadrature (adc_quadrature),
      .rx_enable      (rx_enable),
      .is_armed       (is_armed),
      .sync_found     (sync_found),
      .bit_out        (bit_out),
      .bit_strobe     (bit_strobe),
      .burst_done     (burst_done)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (int'(sync_found) + int'(bit_strobe) + int'(burst_done) > 1) ovl <= ovl + 1;
      if (sync_found) nsync <= nsync + 1;
      if (bit_strobe) begin
         rxq.push_back(bit'(bit_out));
         last_bs <= cyc;
      end
      if (burst_done) begin
         ndone <= ndone + 1;
         done_cyc <= cyc;
         bits_at_done <= rxq.size();
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one strobed sample, then 0 or 1 idle clocks; entered and left at posedge+1
   task automatic send(input int i, input int q);
      sample_strobe = 1'b1;
      adc_inphase = 6'(i);
      adc_quadrature = 6'(q);
      @(posedge clock);
      #1 sample_strobe = 1'b0;
      repeat ($urandom_range(0, 1)) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) send(32 + int'(AMP * $cos(th)), 32 + int'(AMP * $sin(th)));
   endtask

   // continuous-phase modulator: phase slope +-pi/2 per bit, rate = bits per sample
   task automatic modulate(input bit bits[$], input real rate);
      real tp, t1, e, dir;
      int  bi;
      tp = 0.0;
      while (tp < real'(bits.size())) begin
         t1 = tp + rate;
         while (tp < t1) begin
            e = $floor(tp) + 1.0;
            if (e > t1) e = t1;
            bi = int'($floor(tp));
            dir = (bi < bits.size()) ? (bits[bi] ? 1.0 : -1.0) : 0.0;
            th = th + dir * HALFPI * (e - tp);
            tp = e;
         end
         send(32 + int'(AMP * $cos(th)), 32 + int'(AMP * $sin(th)));
      end
   endtask

   // earliest index at which the last 16 bits are within one error of the sync word
   function automatic int first_hit(input bit s[$]);
      logic [15:0] sw_c = 16'hB5E3;
      int d;
      for (int e = 15; e < s.size(); e++) begin
         d = 0;
         for (int k = 0; k < 16; k++) d += int'(s[e-15+k] != sw_c[15-k]);
         if (d <= 1) return e;
      end
      return -1;
   endfunction

   // act: 0 none, 1 drop rx_enable after act_at bits, 2 assert reset after act_at bits
   task automatic burst(input string nm, input int nflip, input real rate, input int act, input int act_at);
      bit          pre[$], sw[$], pay[$], st[$], all[$];
      logic [15:0] sw_c = 16'hB5E3;
      int          tries, target, f0, f1, s_sync, s_done, s_ovl, s_rx, exp_bits, errs, n;
      bit          exp_sync, exp_done;
      target = (nflip <= 1) ? 39 : -1;
      tries = 0;
      do begin
         pre.delete(); sw.delete(); pay.delete(); st.delete();
         f0 = $urandom_range(0, 15);
         f1 = (f0 + 1 + $urandom_range(0, 14)) % 16;
         for (int k = 0; k < 8; k++) pre.push_back(bit'($urandom_range(0, 1)));
         for (int k = 0; k < 16; k++)
            sw.push_back(sw_c[15-k] ^ (nflip > 0 && k == f0) ^ (nflip > 1 && k == f1));
         for (int k = 0; k < 116; k++) pay.push_back(bit'($urandom_range(0, 1)));
         for (int k = 0; k < 16; k++) st.push_back(1'b0);
         st = {st, pre, sw, pay};
         for (int k = 0; k < 16; k++) st.push_back(1'b0);
         tries++;
      end while (first_hit(st) != target && tries < 500);
      all = {pre, sw, pay};
      rx_enable = 1'b0;
      repeat (2) @(posedge clock);
      #1 rx_enable = 1'b1;
      s_sync = nsync; s_done = ndone; s_ovl = ovl; s_rx = rxq.size();
      idle(40);
      fork
         begin
            modulate(all, rate);
            idle(200);
         end
         if (act != 0) begin
            for (n = 0; n < 20000; n++) begin
               @(negedge clock);
               if (rxq.size() - s_rx == act_at) break;
            end
            check({nm, "_act_reached"}, 32'(n < 20000), 1);
            if (act == 1) rx_enable = 1'b0;
            else begin
               #2 reset_n = 1'b0;
               rx_enable = 1'b0;
               #1 check({nm, "_rst_outs"}, {is_armed, sync_found, bit_out, bit_strobe, burst_done}, 0);
            end
         end
      join
      exp_sync = (nflip <= 1);
      exp_bits = !exp_sync ? 0 : (act != 0) ? act_at : 116;
      exp_done = exp_sync && act == 0;
      check({nm, "_syncs"}, nsync - s_sync, 32'(exp_sync));
      check({nm, "_bits"}, rxq.size() - s_rx, exp_bits);
      check({nm, "_dones"}, ndone - s_done, 32'(exp_done));
      check({nm, "_overlap"}, ovl - s_ovl, 0);
`ifdef GMSK_RX_TIMING_TRACK_EN
      if (exp_sync) begin
`else
      if (exp_sync && rate < NOM + 1e-6) begin
`endif
         errs = 0;
         for (int i = 0; i < exp_bits && s_rx + i < rxq.size(); i++) errs += int'(rxq[s_rx+i] != pay[i]);
         check({nm, "_bit_errs"}, errs, 0);
      end
      if (exp_done) begin
         check({nm, "_bits_before_done"}, bits_at_done - s_rx, 116);
         check({nm, "_done_after_last"}, 32'(done_cyc > last_bs), 1);
      end
      if (nflip > 1) check({nm, "_armed"}, 32'(is_armed), 1);
   endtask

   initial begin
      int s0, r0;
      #12;
      check("reset_outs", {is_armed, sync_found, bit_out, bit_strobe, burst_done}, 0);
      check("reset_armed", 32'(is_armed), 0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("idle_disabled", 32'(is_armed), 0);
      @(posedge clock);
      #1;
      burst("clean", 0, NOM, 0, 0);
      burst("flip1", 1, NOM, 0, 0);
      burst("flip2", 2, NOM, 0, 0);
      rx_enable = 1'b0;
      @(posedge clock);
      #1 rx_enable = 1'b1;
      s0 = nsync; r0 = rxq.size();
      repeat (300) send(63, 32);
      check("const_syncs", nsync - s0, 0);
      check("const_bits", rxq.size() - r0, 0);
      check("const_armed", 32'(is_armed), 1);
      burst("drop", 0, NOM, 1, 50);
      burst("rst", 0, NOM, 2, 30);
      repeat (5) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (10) @(posedge clock);
      @(negedge clock);
      check("post_rst_idle", 32'(is_armed), 0);
      @(posedge clock);
      #1 rx_enable = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("post_rst_armed", 32'(is_armed), 1);
      @(posedge clock);
      #1;
      burst("fast", 0, NOM * 1.005, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
